// File: rtl/conv_enc_pkg.sv
// Shared types and default parameters for the tail-biting convolutional encoder.
package conv_enc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENCODE = 2'd1,
      ST_DRAIN  = 2'd2
   } enc_state_t;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_K       = 7;
   localparam int DEF_N_OUT   = 3;
   localparam int DEF_LEN_W   = 13;
   localparam int DEF_MAX_LEN = 6144;

   // LTE rate-1/3 mother code; the first entry drives the MSB of the symbol
   localparam logic [6:0]  LTE_G0   = 7'o133;
   localparam logic [6:0]  LTE_G1   = 7'o171;
   localparam logic [6:0]  LTE_G2   = 7'o165;
   localparam logic [20:0] LTE_GENS = {LTE_G0, LTE_G1, LTE_G2};

endpackage

// File: rtl/conv_enc_parity.sv
// Combinational parity network: one XOR-reduced generator tap set per coded bit.
module conv_enc_parity
   import conv_enc_pkg::*;
#(
   parameter int                 K     = DEF_K,
   parameter int                 N_OUT = DEF_N_OUT,
   parameter logic [N_OUT*K-1:0] GENS  = LTE_GENS
) (
   input  logic [K-1:0]     win,
   output logic [N_OUT-1:0] par
);

   // Generator slice i*K lands on par[i], so the first-listed generator feeds the MSB
   always_comb begin
      par = '0;
      for (int i = 0; i < N_OUT; i++) begin
         par[i] = ^(win & GENS[i*K +: K]);
      end
   end

endmodule

// File: rtl/conv_encoder_tb.sv
// Tail-biting convolutional encoder: serialises FIFO words LSB-first into coded
// symbols on a valid/ready stream and flags a start/end state mismatch.
module conv_encoder_tb
   import conv_enc_pkg::*;
#(
   parameter int                 DATA_W  = DEF_DATA_W,
   parameter int                 K       = DEF_K,
   parameter int                 N_OUT   = DEF_N_OUT,
   parameter logic [N_OUT*K-1:0] GENS    = LTE_GENS,
   parameter int                 LEN_W   = DEF_LEN_W,
   parameter int                 MAX_LEN = DEF_MAX_LEN
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  blk_len,
   input  logic [K-2:0]      tail_bits,
   input  logic [DATA_W-1:0] fifo_data,
   input  logic              fifo_empty,
   output logic              fifo_rdreq,
   output logic [N_OUT-1:0]  d_out,
   output logic              d_valid,
   input  logic              d_ready,
   output logic              d_last,
   output logic              busy,
   output logic              done,
   output logic              err_len,
   output logic              tb_mismatch
);

   localparam int              PTR_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DATA_W - 1);

   function automatic logic len_legal(input logic [LEN_W-1:0] len);
      return (len != '0) && ((int'(len) % DATA_W) == 0) && (int'(len) <= MAX_LEN);
   endfunction

   // New bit enters at s1 (MSB of the state vector), oldest bit falls off the LSB
   function automatic logic [K-2:0] shift_in(input logic [K-2:0] s, input logic b);
      logic [K-1:0] t;
      t = {b, s};
      return t[K-1:1];
   endfunction

   enc_state_t        state_q, state_d;
   logic [K-2:0]      shreg_p0;
   logic [K-2:0]      start_st_p0;
   logic [PTR_W-1:0]  ptr_p0;
   logic [LEN_W-1:0]  cnt_p0;
   logic [LEN_W-1:0]  len_p0;

   logic [N_OUT-1:0]  sym_p1;
   logic              vld_p1;
   logic              last_p1;
   logic              done_q;
   logic              err_q;
   logic              tbm_q;

   logic              u;
   logic [K-1:0]      window;
   logic [N_OUT-1:0]  parity;
   logic [K-2:0]      shreg_nxt;
   logic              accept;
   logic              step;
   logic              last_bit;
   logic              start_ok;

   // ---- stage p0: bit select, window and step qualification ----
   assign u         = fifo_data[ptr_p0];
   assign window    = {u, shreg_p0};
   assign shreg_nxt = shift_in(shreg_p0, u);
   assign accept    = vld_p1 & d_ready;
   assign step      = (state_q == ST_ENCODE) & ~fifo_empty & (~vld_p1 | d_ready);
   assign last_bit  = (cnt_p0 == (len_p0 - LEN_W'(1)));
   assign start_ok  = len_legal(blk_len);

   // The pop is combinational so the FIFO advances on the same edge that consumes the last bit
   assign fifo_rdreq = reset & step & (ptr_p0 == PTR_LAST);

   conv_enc_parity #(
      .K     (K),
      .N_OUT (N_OUT),
      .GENS  (GENS)
   ) u_parity (
      .win (window),
      .par (parity)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start && start_ok) state_d = ST_ENCODE;
         ST_ENCODE: if (step && last_bit)  state_d = ST_DRAIN;
         ST_DRAIN:  if (accept)            state_d = ST_IDLE;
         default:                          state_d = ST_IDLE;
      endcase
   end

   // ---- stage p1: registered symbol, handshake and status ----
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         shreg_p0    <= '0;
         start_st_p0 <= '0;
         ptr_p0      <= '0;
         cnt_p0      <= '0;
         len_p0      <= '0;
         sym_p1      <= '0;
         vld_p1      <= 1'b0;
         last_p1     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         tbm_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (start_ok) begin
                     len_p0      <= blk_len;
                     start_st_p0 <= tail_bits;
                     shreg_p0    <= tail_bits;
                     ptr_p0      <= '0;
                     cnt_p0      <= '0;
                     tbm_q       <= 1'b0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            ST_ENCODE: begin
               if (step) begin
                  sym_p1   <= parity;
                  vld_p1   <= 1'b1;
                  last_p1  <= last_bit;
                  shreg_p0 <= shreg_nxt;
                  ptr_p0   <= (ptr_p0 == PTR_LAST) ? '0 : ptr_p0 + PTR_W'(1);
                  cnt_p0   <= cnt_p0 + LEN_W'(1);
                  // A tail-biting block must end in exactly the state it started from
                  if (last_bit && (shreg_nxt != start_st_p0)) tbm_q <= 1'b1;
               end else if (accept) begin
                  vld_p1 <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (accept) begin
                  vld_p1  <= 1'b0;
                  last_p1 <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign d_out       = sym_p1;
   assign d_valid     = vld_p1;
   assign d_last      = last_p1;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign err_len     = err_q;
   assign tb_mismatch = tbm_q;

endmodule

// File: doc/conv_encoder_tb.md
Name: conv_encoder_tb

Overview:
Parametrised tail-biting convolutional encoder (rate 1/N_OUT, constraint length K) for the transmit chain. Pops packed data words from a show-ahead input FIFO and serialises them LSB-first. Emits one N_OUT-bit coded symbol per input bit over a valid/ready stream. The block length is programmable per block, not a two-size select. At block end it checks that the tail-biting end state equals the preloaded start state.

Parameters:
DATA_W, 8, input FIFO word width in bits
K, 7, constraint length; shift state is K-1 bits
N_OUT, 3, coded bits per input bit
GENS, {7'o133,7'o171,7'o165}, N_OUT packed K-bit generators; entry j drives d_out[N_OUT-1-j]; generator MSB taps the current input bit
LEN_W, 13, width of blk_len
MAX_LEN, 6144, largest legal block length in bits

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-low
start  in  1  begin a block; sampled only in IDLE
blk_len  in  LEN_W  block length in bits, sampled with start
tail_bits  in  K-1  last K-1 block bits; [K-2]=last bit, [0]=(K-1)th-to-last, sampled with start
fifo_data  in  DATA_W  show-ahead FIFO head word; bit 0 is encoded first
fifo_empty  in  1  FIFO empty flag
fifo_rdreq  out  1  pop FIFO head, combinational, one cycle per word
d_out  out  N_OUT  coded symbol, registered
d_valid  out  1  d_out valid
d_ready  in  1  downstream accepts d_out
d_last  out  1  marks the last symbol of the block
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse when the last symbol is accepted
err_len  out  1  one-cycle pulse when start is rejected
tb_mismatch  out  1  sticky end-state mismatch flag; cleared by the next accepted start

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE; every output 0; shift state, bit pointer and bit counter 0. Reset overrides all other events, including mid-block; no FIFO pop occurs in a reset cycle.
- States: IDLE, ENCODE, DRAIN.
- IDLE: start=1 with blk_len legal (nonzero, multiple of DATA_W, <= MAX_LEN):
  - latch length and tail_bits; shift state s1..s(K-1) = tail_bits[K-2]..tail_bits[0]
  - pointer=0, count=0, clear tb_mismatch; go to ENCODE next cycle
- IDLE: start=1 with illegal blk_len: err_len pulse next cycle; stay IDLE.
- start outside IDLE is ignored.
- ENCODE step fires when fifo_empty=0 and (d_valid=0 or d_ready=1):
  - u = fifo_data[pointer]; window w = {u, s1..s(K-1)}, u at the MSB
  - d_out[N_OUT-1-j] <= XOR(w & GENS[j]); d_valid <= 1
  - shift state (s1 <= u); pointer++; count++
- fifo_rdreq=1 in the step cycle where pointer=DATA_W-1; pointer wraps to 0.
- fifo_empty=1 stalls ENCODE: no step, no pop, held d_out stays valid.
- Output hold: d_valid=1 and d_ready=0 holds d_out, d_last, state and pointer.
- d_valid clears when a symbol is accepted and no new step fires in the same cycle.
- Last bit (count = len-1):
  - that step sets d_last=1 and goes to DRAIN
  - the post-shift state is compared with the latched start state; mismatch sets tb_mismatch
- DRAIN: once d_valid=1 and d_ready=1 → d_valid=0, d_last=0, done pulse, go to IDLE. A start in that same cycle is ignored.
- Latency: the first symbol is valid 2 cycles after an accepted start if the FIFO is non-empty. Throughput is 1 symbol/cycle under d_ready=1.
- Count width is LEN_W; blk_len=MAX_LEN must not overflow.

Decomposition:
- Package conv_enc_pkg holds:
  - FSM state enum (IDLE/ENCODE/DRAIN)
  - LTE default generator constants 7'o133, 7'o171, 7'o165
  - default K, N_OUT, DATA_W, LEN_W, MAX_LEN
- Sub-module conv_enc_parity: purely combinational, K-bit window → N_OUT parity bits, parametrised by GENS.
- FSM, counters and handshake stay in the top level.

Test Plan:
- Reset, then no start → all outputs 0 for 10 cycles; fifo_rdreq never asserted.
- blk_len=8, fifo_data=8'hFF, tail_bits=6'h3F, d_ready=1 → 8 symbols of 3'b111; d_last on the 8th; done pulse; exactly one pop; tb_mismatch=0.
- blk_len=8, fifo_data=8'h00, tail_bits=6'h3F → first symbol 3'b000; tb_mismatch=1 after done.
- blk_len=16 (two words 8'hFF, 8'h00, consistent tail 6'h00) with d_ready=0 for 5 cycles at symbol 3 → d_out held, no extra pops, still 16 symbols and 2 pops; fifo_empty=1 for 3 cycles between words → stall, no symbols lost.
- start with blk_len=0, then 12, then 6152 → err_len pulse each time; busy stays 0.
- reset=0 during symbol 5 of a 6144-bit block → next cycle all outputs 0, IDLE; a fresh 8-bit block then encodes correctly.
